// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a scanned 7-segment display: de-glitches each digit, decodes it to BCD and rebuilds frames.
// Latency 1 + STABLE_CYC + 1 cycles from the final digit change to frame_valid; pure observer, so there is no backpressure.
module seg_scan_decoder #(
  parameter int NUM_POS        = 5,
  parameter int STABLE_CYC     = 4,
  parameter int TIMEOUT        = 1024,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a,
  input  logic                   b,
  input  logic                   c,
  input  logic                   d,
  input  logic                   e,
  input  logic                   f,
  input  logic                   g,
  input  logic                   dp,
  input  logic [NUM_POS-1:0]     position,
  output logic [4*NUM_POS-1:0]   digits,
  output logic [NUM_POS-1:0]     dps,
  output logic                   frame_valid,
  output logic                   seg_err,
  output logic                   pos_err,
  output logic                   scan_lost
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] STABLE_MAX  = CW'(STABLE_CYC);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT);
  localparam logic [7:0]    POL_MASK    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  // samp_* holds {a..g, dp} normalised so that 1 always means lit
  logic [7:0]           samp_q, samp_d;
  logic [NUM_POS-1:0]   pos_q, pos_d;
  logic [7:0]           prev_samp_q, prev_samp_d;
  logic [NUM_POS-1:0]   prev_pos_q, prev_pos_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        to_q, to_d;
  logic [NUM_POS-1:0]   seen_q, seen_d;
  logic [4*NUM_POS-1:0] work_code_q, work_code_d;
  logic [NUM_POS-1:0]   work_dp_q, work_dp_d;
  logic                 cmpl_q, cmpl_d;
  logic [4*NUM_POS-1:0] digits_q, digits_d;
  logic [NUM_POS-1:0]   dps_q, dps_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 seg_err_q, seg_err_d;
  logic                 pos_err_q, pos_err_d;
  logic                 scan_lost_q, scan_lost_d;

  logic                 same;
  logic                 reach;
  logic                 multi_hot;
  logic                 one_hot;
  logic                 accept;
  logic [3:0]           code;
  logic [NUM_POS-1:0]   seen_base;
  logic [NUM_POS-1:0]   seen_next;
  logic                 timeout_hit;

  function automatic logic [3:0] seg_decode(input logic [6:0] lit);
    case (lit)
      7'b1111110: seg_decode = 4'd0;
      7'b0110000: seg_decode = 4'd1;
      7'b1101101: seg_decode = 4'd2;
      7'b1111001: seg_decode = 4'd3;
      7'b0110011: seg_decode = 4'd4;
      7'b1011011: seg_decode = 4'd5;
      7'b1011111: seg_decode = 4'd6;
      7'b1110000: seg_decode = 4'd7;
      7'b1111111: seg_decode = 4'd8;
      7'b1111011: seg_decode = 4'd9;
      7'b0000000: seg_decode = 4'hE;
      default:    seg_decode = 4'hF;
    endcase
  endfunction

  always_comb begin
    samp_d      = {a, b, c, d, e, f, g, dp} ^ POL_MASK;
    pos_d       = position;
    prev_samp_d = samp_q;
    prev_pos_d  = pos_q;

    same  = (samp_q == prev_samp_q) && (pos_q == prev_pos_q);
    cnt_d = same ? ((cnt_q == STABLE_MAX) ? cnt_q : cnt_q + CW'(1)) : CW'(1);
    // A saturated counter that stays equal is the same run: fire only on the arrival at STABLE_MAX
    reach = (cnt_d == STABLE_MAX) && (!same || (cnt_q != STABLE_MAX));

    multi_hot = |(pos_q & (pos_q - NUM_POS'(1)));
    one_hot   = (|pos_q) && !multi_hot;
    accept    = reach && one_hot;
    code      = seg_decode(samp_q[7:1]);

    // Seen bits from the frame just completed must not count toward the next one
    seen_base = cmpl_q ? '0 : seen_q;
    seen_next = accept ? (seen_base | pos_q) : seen_base;
    cmpl_d    = accept && (&seen_next);

    to_d        = accept ? '0 : ((to_q == TIMEOUT_MAX) ? to_q : to_q + TW'(1));
    timeout_hit = !accept && (to_d == TIMEOUT_MAX);
    seen_d      = timeout_hit ? '0 : seen_next;
    scan_lost_d = accept ? 1'b0 : (timeout_hit ? 1'b1 : scan_lost_q);

    work_code_d = work_code_q;
    work_dp_d   = work_dp_q;
    for (int i = 0; i < NUM_POS; i++) begin
      if (accept && pos_q[i]) begin
        work_code_d[4*i +: 4] = code;
        work_dp_d[i]          = samp_q[0];
      end
    end

    digits_d      = cmpl_q ? work_code_q : digits_q;
    dps_d         = cmpl_q ? work_dp_q : dps_q;
    frame_valid_d = cmpl_q;
    seg_err_d     = accept && (code == 4'hF);
    pos_err_d     = pos_err_q | (reach && multi_hot);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      samp_q        <= '0;
      pos_q         <= '0;
      prev_samp_q   <= '0;
      prev_pos_q    <= '0;
      cnt_q         <= '0;
      to_q          <= '0;
      seen_q        <= '0;
      work_code_q   <= {NUM_POS{4'hE}};
      work_dp_q     <= '0;
      cmpl_q        <= 1'b0;
      digits_q      <= {NUM_POS{4'hE}};
      dps_q         <= '0;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      pos_err_q     <= 1'b0;
      scan_lost_q   <= 1'b0;
    end else begin
      samp_q        <= samp_d;
      pos_q         <= pos_d;
      prev_samp_q   <= prev_samp_d;
      prev_pos_q    <= prev_pos_d;
      cnt_q         <= cnt_d;
      to_q          <= to_d;
      seen_q        <= seen_d;
      work_code_q   <= work_code_d;
      work_dp_q     <= work_dp_d;
      cmpl_q        <= cmpl_d;
      digits_q      <= digits_d;
      dps_q         <= dps_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
      pos_err_q     <= pos_err_d;
      scan_lost_q   <= scan_lost_d;
    end
  end

  assign digits      = digits_q;
  assign dps         = dps_q;
  assign frame_valid = frame_valid_q;
  assign seg_err     = seg_err_q;
  assign pos_err     = pos_err_q;
  assign scan_lost   = scan_lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: frame scoreboard fed from a behavioural display model.
module tb_seg_scan_decoder;
  localparam int NUM_POS    = 5;
  localparam int STABLE_CYC = 4;
  localparam int TIMEOUT    = 1024;
  localparam logic [6:0] BAD   = 7'b1000001;
  localparam logic [6:0] BLANK = 7'b0000000;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        a, b, c, d, e, f, g, dp;
  logic [4:0]  position;
  logic [19:0] digits;
  logic [4:0]  dps;
  logic        frame_valid, seg_err, pos_err, scan_lost;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_drive_cyc = 0;
  int last_fv_cyc    = 0;
  int fv_cnt         = 0;
  int seg_err_cnt    = 0;
  int exp_seg_err    = 0;
  int exp_frames     = 0;

  logic [24:0] sb_q[$];
  logic [19:0] m_dig        = 20'hEEEEE;
  logic [4:0]  m_dps        = '0;
  logic [4:0]  m_seen       = '0;
  logic [19:0] last_exp_dig = 20'hEEEEE;
  logic [4:0]  last_exp_dps = '0;

  seg_scan_decoder #(
    .NUM_POS(NUM_POS), .STABLE_CYC(STABLE_CYC), .TIMEOUT(TIMEOUT), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .position(position),
    .digits(digits), .dps(dps), .frame_valid(frame_valid),
    .seg_err(seg_err), .pos_err(pos_err), .scan_lost(scan_lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] pat(input int dgt);
    case (dgt)
      0: pat = 7'b1111110;
      1: pat = 7'b0110000;
      2: pat = 7'b1101101;
      3: pat = 7'b1111001;
      4: pat = 7'b0110011;
      5: pat = 7'b1011011;
      6: pat = 7'b1011111;
      7: pat = 7'b1110000;
      8: pat = 7'b1111111;
      9: pat = 7'b1111011;
      default: pat = 7'b0000000;
    endcase
  endfunction

  // Drive one pattern (lit = 1) for hold cycles; a one-hot hold of STABLE_CYC or more updates the model
  task automatic show(input logic [4:0] pos, input logic [6:0] lit, input logic dpl,
                      input logic [3:0] code, input int hold);
    {a, b, c, d, e, f, g} = ~lit;
    dp       = ~dpl;
    position = pos;
    last_drive_cyc = cyc;
    if (hold >= STABLE_CYC && $countones(pos) == 1) begin
      for (int i = 0; i < NUM_POS; i++) begin
        if (pos[i]) begin
          m_dig[4*i +: 4] = code;
          m_dps[i]        = dpl;
          m_seen[i]       = 1'b1;
        end
      end
      if (code == 4'hF) exp_seg_err++;
      if (&m_seen) begin
        sb_q.push_back({m_dps, m_dig});
        exp_frames++;
        last_exp_dig = m_dig;
        last_exp_dps = m_dps;
        m_seen = '0;
      end
    end
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic scan(input int c0, input int c1, input int c2, input int c3, input int c4,
                      input logic [4:0] dpm);
    show(5'b00001, pat(c0), dpm[0], 4'(c0), 8);
    show(5'b00010, pat(c1), dpm[1], 4'(c1), 8);
    show(5'b00100, pat(c2), dpm[2], 4'(c2), 8);
    show(5'b01000, pat(c3), dpm[3], 4'(c3), 8);
    show(5'b10000, pat(c4), dpm[4], 4'(c4), 8);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_valid) begin
        fv_cnt++;
        last_fv_cyc = cyc;
        if (sb_q.size() == 0) begin
          chk("frame_unexpected", 32'd1, 32'd0);
        end else begin
          logic [24:0] exp;
          exp = sb_q.pop_front();
          chk("frame_digits", 32'(digits), 32'(exp[19:0]));
          chk("frame_dps", 32'(dps), 32'(exp[24:20]));
        end
      end
      if (seg_err) seg_err_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "bench did not complete");
  end

  initial begin
    position = '0;
    {a, b, c, d, e, f, g} = 7'h7F;
    dp = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", 32'(digits), 32'hEEEEE);
    chk("rst_dps", 32'(dps), 32'd0);
    chk("rst_fv", 32'(frame_valid), 32'd0);
    chk("rst_seg_err", 32'(seg_err), 32'd0);
    chk("rst_pos_err", 32'(pos_err), 32'd0);
    chk("rst_scan_lost", 32'(scan_lost), 32'd0);
    reset = 1'b0;

    // Basic frame "12345" with dp on position 2
    scan(1, 2, 3, 4, 5, 5'b00100);
    chk("t1_latency", 32'(last_fv_cyc - last_drive_cyc), 32'd6);
    chk("t1_digits", 32'(digits), 32'h54321);
    chk("t1_dps", 32'(dps), 32'b00100);
    chk("t1_frames", 32'(fv_cnt), 32'd1);
    chk("t1_seg_err", 32'(seg_err_cnt), 32'd0);
    chk("t1_pos_err", 32'(pos_err), 32'd0);
    chk("t1_scan_lost", 32'(scan_lost), 32'd0);

    // Glitches shorter than STABLE_CYC are ignored; exactly STABLE_CYC is accepted
    show(5'b00001, pat(1), 1'b0, 4'd1, 2);
    show(5'b00001, pat(3), 1'b0, 4'd3, 8);
    show(5'b00010, pat(8), 1'b0, 4'd8, 3);
    show(5'b00010, pat(6), 1'b0, 4'd6, 8);
    show(5'b00100, pat(7), 1'b1, 4'd7, STABLE_CYC);
    show(5'b01000, pat(8), 1'b0, 4'd8, 8);
    show(5'b10000, pat(9), 1'b0, 4'd9, 8);
    chk("t2_slot0", 32'(digits[3:0]), 32'h3);
    chk("t2_frames", 32'(fv_cnt), 32'(exp_frames));

    // Undecodable pattern, blank digit, and an overwrite of slot 2
    show(5'b00001, pat(0), 1'b0, 4'd0, 8);
    show(5'b00010, BLANK,  1'b0, 4'hE, 8);
    show(5'b00100, pat(7), 1'b0, 4'd7, 8);
    show(5'b00100, pat(2), 1'b0, 4'd2, 8);
    show(5'b01000, BAD,    1'b0, 4'hF, 8);
    show(5'b10000, pat(9), 1'b1, 4'd9, 8);
    chk("t3_slot3", 32'(digits[15:12]), 32'hF);
    chk("t3_slot1", 32'(digits[7:4]), 32'hE);
    chk("t3_seg_err", 32'(seg_err_cnt), 32'(exp_seg_err));

    // Multi-hot position mid-frame: flags pos_err and writes nothing
    show(5'b00001, pat(5), 1'b0, 4'd5, 8);
    show(5'b00010, pat(6), 1'b0, 4'd6, 8);
    show(5'b00100, pat(7), 1'b0, 4'd7, 8);
    show(5'b01000, pat(2), 1'b0, 4'd2, 8);
    show(5'b00011, pat(8), 1'b0, 4'd8, 10);
    chk("t4_pos_err_set", 32'(pos_err), 32'd1);
    show(5'b10000, pat(3), 1'b0, 4'd3, 8);
    scan(0, 1, 2, 3, 4, 5'b00000);
    chk("t4_pos_err_sticky", 32'(pos_err), 32'd1);
    chk("t4_frames", 32'(fv_cnt), 32'(exp_frames));

    // Partial frame, then unstable input until the timeout fires
    show(5'b00001, pat(4), 1'b0, 4'd4, 8);
    show(5'b00010, pat(5), 1'b0, 4'd5, 8);
    show(5'b00100, pat(6), 1'b0, 4'd6, 8);
    for (int k = 0; k < (TIMEOUT + 40) / 3 + 1; k++)
      show(5'b00001, (k % 2 == 1) ? pat(7) : pat(1), 1'b0, 4'd0, 3);
    m_seen = '0;
    chk("t5_scan_lost", 32'(scan_lost), 32'd1);
    chk("t5_digits_held", 32'(digits), 32'(last_exp_dig));
    chk("t5_dps_held", 32'(dps), 32'(last_exp_dps));
    chk("t5_no_frame", 32'(fv_cnt), 32'(exp_frames));
    show(5'b01000, pat(1), 1'b0, 4'd1, STABLE_CYC);
    chk("t5_lost_before_acc", 32'(scan_lost), 32'd1);
    @(posedge clk);
    #1;
    chk("t5_lost_cleared", 32'(scan_lost), 32'd0);
    show(5'b10000, pat(2), 1'b0, 4'd2, 8);
    chk("t5_partial_no_frame", 32'(fv_cnt), 32'(exp_frames));
    show(5'b00001, pat(7), 1'b0, 4'd7, 8);
    show(5'b00010, pat(8), 1'b0, 4'd8, 8);
    show(5'b00100, pat(9), 1'b1, 4'd9, 8);
    chk("t5_resumed_frame", 32'(fv_cnt), 32'(exp_frames));
    chk("t5_digits", 32'(digits), 32'h21987);

    // Reset with four of five slots seen discards the partial frame
    show(5'b00001, pat(1), 1'b0, 4'd1, 8);
    show(5'b00010, pat(1), 1'b1, 4'd1, 8);
    show(5'b00100, pat(1), 1'b0, 4'd1, 8);
    show(5'b01000, pat(1), 1'b0, 4'd1, 8);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_seen = '0;
    chk("t6_digits", 32'(digits), 32'hEEEEE);
    chk("t6_dps", 32'(dps), 32'd0);
    chk("t6_fv", 32'(frame_valid), 32'd0);
    chk("t6_seg_err", 32'(seg_err), 32'd0);
    chk("t6_pos_err", 32'(pos_err), 32'd0);
    chk("t6_scan_lost", 32'(scan_lost), 32'd0);
    reset = 1'b0;
    show(5'b10000, pat(6), 1'b0, 4'd6, 8);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_frame", 32'(fv_cnt), 32'(exp_frames));
    chk("t6_digits_after", 32'(digits), 32'hEEEEE);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("seg_err_total", 32'(seg_err_cnt), 32'(exp_seg_err));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive side of the multiplexed 7-segment display interface driven by the stopwatch: samples segments a..g, dp and the one-hot position strobe.
- De-glitches scan transitions, decodes each digit back to BCD and assembles complete display frames.
- Used for on-board loopback self-check and as a synthesizable display monitor in system simulation.

Parameters:
- NUM_POS, 5: number of scanned digit positions (width of position).
- STABLE_CYC, 4: consecutive identical samples required before a digit is accepted (range 1..255).
- TIMEOUT, 1024: cycles without an accepted digit before scan_lost asserts (range 2..65535).
- SEG_ACTIVE_LOW, 1: 1 means a segment is lit when its input is 0; 0 means lit when 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- a,b,c,d,e,f,g  input  1 each  segment drives.
- dp  input  1  decimal point drive, same polarity as the segments.
- position  input  NUM_POS  one-hot, active-high digit select.
- digits  output  4*NUM_POS  frame BCD codes; position i occupies bits [4i+3:4i].
- dps  output  NUM_POS  frame decimal-point lit flags, 1 = lit.
- frame_valid  output  1  one-cycle pulse when digits/dps are updated.
- seg_err  output  1  one-cycle pulse when an accepted digit has an undecodable pattern.
- pos_err  output  1  sticky; set when position is multi-hot for STABLE_CYC consecutive cycles.
- scan_lost  output  1  level; no digit accepted for TIMEOUT cycles.

Behaviour:
- Reset values: digits = all 4'hE, dps = 0, frame_valid = 0, seg_err = 0, pos_err = 0, scan_lost = 0. Internal seen mask, stability counter and timeout counter are all cleared.
- Reset mid-frame discards any partial frame; no frame_valid pulse follows the reset.
- Input stage: a..g, dp and position are registered once. Polarity is normalised to lit = 1 when SEG_ACTIVE_LOW = 1.
- Stability filter:
  - The registered {position, segs, dp} is compared with the previous registered sample.
  - Equal: the counter increments, saturating at STABLE_CYC.
  - Different: the counter reloads to 1.
  - Acceptance fires on the cycle the counter reaches STABLE_CYC, and only if position is exactly one-hot. One acceptance per stable run; re-arm only after a change.
- Position = 0 (blanking gap): never accepted, not an error.
- Multi-hot position stable for STABLE_CYC cycles: sets pos_err; no acceptance.
- Decode, lit pattern {a..g} for digits 0-9: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.
  - All off (0000000) decodes to 4'hE (blank).
  - Any other pattern decodes to 4'hF and pulses seg_err in the acceptance cycle.
- Accept at position i writes the working code and dp registers for slot i and sets seen[i].
- A repeated accept of the same slot before frame completion overwrites the slot with the newest value.
- Frame completion: on the accept that makes seen all ones:
  - Next cycle: the working registers are copied to digits/dps (including that last write), frame_valid = 1 for exactly one cycle, and seen clears.
  - digits/dps hold stable between frames.
- Latency: segment change to frame_valid is 1 (input register) + STABLE_CYC + 1 cycles, measured for the final position of a frame.
- Timeout:
  - The counter clears on every accept and otherwise increments, saturating.
  - When it reaches TIMEOUT: scan_lost = 1 and seen clears. digits/dps are not modified.
  - The first subsequent accept clears scan_lost in the same cycle that seen[i] is set.
  - An accept and a timeout in the same cycle: the accept wins.
- pos_err clears only on reset.

Test Plan:
- Scan "1","2","3","4","5" on positions 0..4, each held 8 cycles, active-low patterns, dp lit on position 2 -> one frame_valid pulse; digits = 20'h54321; dps = 5'b00100; seg_err, pos_err, scan_lost stay 0.
- Segment glitch: pattern 0110000 shown for 2 cycles, then 1111001 held on position 0, STABLE_CYC = 4 -> slot 0 = 3, never 1; after the remaining positions, frame digits[3:0] = 4'h3.
- Pattern 1000001 stable on position 3 -> seg_err pulses once; slot 3 = 4'hF in the next frame; all-off pattern on position 1 -> slot 1 = 4'hE with no seg_err.
- position = 5'b00011 held 10 cycles -> pos_err = 1 and stays 1 through the following valid frames; no accept occurs during that window.
- Scan stops after 3 positions; inputs held at position 0 with a change every 3 cycles for TIMEOUT cycles -> scan_lost = 1, digits unchanged, no frame_valid; scan resumes -> scan_lost drops on the first accept, and the full frame needs all 5 positions again.
- Reset asserted after 4 of 5 positions accepted -> all outputs return to their reset values; completing only position 4 afterwards produces no frame_valid.
